// File: rtl/mdu_sched.sv
// Multiply/divide scheduler for the E stage.
// Owns architectural HI/LO, computes mult/multu/div/divu results at accept time
// and commits them after a fixed latency modelled by a down-counter.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   E_MDOp[2:0]         - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   E_Start             - qualifies E_MDOp 1..4 this cycle
//   E_A, E_B [31:0]     - rs / rt operands
//   Req                 - exception/interrupt flush of the E-stage instruction
//   E_Busy              - combinational, high while an operation is in flight
//   E_HI, E_LO [31:0]   - architectural HI / LO
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        Req,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      pend_hi, pend_hi_nxt;
    logic [31:0]      pend_lo, pend_lo_nxt;
    logic             pend_wr, pend_wr_nxt;
    logic [31:0]      hi_nxt, lo_nxt;

    logic             idle;
    logic             accept;
    logic             mt_wr;
    logic             div_zero;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      div_b;
    logic [31:0]      abs_a, abs_b;
    logic [31:0]      q_mag, r_mag;
    logic [31:0]      q_s, r_s, q_u, r_u;
    logic [31:0]      res_hi, res_lo;

    assign E_Busy = (cnt != '0);

    // Issue qualification: only an idle unit with no flush this cycle accepts work.
    assign idle     = (cnt == '0);
    assign accept   = E_Start && !Req && idle &&
                      (E_MDOp == OP_MULT || E_MDOp == OP_MULTU ||
                       E_MDOp == OP_DIV  || E_MDOp == OP_DIVU);
    assign mt_wr    = !Req && idle && (E_MDOp == OP_MTHI || E_MDOp == OP_MTLO);
    assign div_zero = (E_B == 32'd0);

    // Arithmetic datapath. Signed divide works on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 without relying on simulator overflow behaviour.
    always_comb begin
        prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        prod_u = {32'd0, E_A} * {32'd0, E_B};
        div_b  = div_zero ? 32'd1 : E_B;
        abs_a  = E_A[31]   ? (32'd0 - E_A)   : E_A;
        abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
        q_mag  = abs_a / abs_b;
        r_mag  = abs_a % abs_b;
        q_s    = (E_A[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
        r_s    = E_A[31] ? (32'd0 - r_mag) : r_mag;
        q_u    = E_A / div_b;
        r_u    = E_A % div_b;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (E_MDOp)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
        endcase
    end

    // Next-state: accept loads the counter and pending result; otherwise count down
    // and commit on the last busy edge. An in-flight op is never cancelled by Req.
    always_comb begin
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        hi_nxt      = E_HI;
        lo_nxt      = E_LO;

        if (accept) begin
            pend_hi_nxt = res_hi;
            pend_lo_nxt = res_lo;
            if (E_MDOp == OP_MULT || E_MDOp == OP_MULTU) begin
                cnt_nxt     = CNT_W'(MULT_CYCLES);
                pend_wr_nxt = 1'b1;
            end else begin
                cnt_nxt     = CNT_W'(DIV_CYCLES);
                pend_wr_nxt = !div_zero;
            end
        end else if (!idle) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && pend_wr) begin
                hi_nxt = pend_hi;
                lo_nxt = pend_lo;
            end
        end

        if (mt_wr) begin
            if (E_MDOp == OP_MTHI) hi_nxt = E_A;
            else                   lo_nxt = E_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            E_HI    <= 32'd0;
            E_LO    <= 32'd0;
        end else begin
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
            E_HI    <= hi_nxt;
            E_LO    <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: a vector table for the arithmetic/latency cases
// plus hand-written sequences for busy-time starts, Req flushes and mid-op reset.
module tb_mdu_sched;

    logic        clk;
    logic        reset;
    logic [2:0]  E_MDOp;
    logic        E_Start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        Req;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDOp  (E_MDOp),
        .E_Start (E_Start),
        .E_A     (E_A),
        .E_B     (E_B),
        .Req     (Req),
        .E_Busy  (E_Busy),
        .E_HI    (E_HI),
        .E_LO    (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDOp = op; E_Start = 1'b1; E_A = a; E_B = b;
        step();
        E_MDOp = 3'd0; E_Start = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        E_MDOp = op; E_A = a;
        step();
        E_MDOp = 3'd0;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        mt(3'd5, h);
        mt(3'd6, l);
    endtask

    initial begin
        int n;

        vecs[0] = '{"mult_neg1x2",   3'd1, 32'hFFFFFFFF, 32'h00000002,  5, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{"multu_maxx2",   3'd2, 32'hFFFFFFFF, 32'h00000002,  5, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{"div_m7_2",      3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_7_2",      3'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4] = '{"div_min_m1",    3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5] = '{"div_by_zero",   3'd3, 32'h00000005, 32'h00000000, 10, 32'h11111111, 32'h22222222};
        vecs[6] = '{"divu_by_zero",  3'd4, 32'h00000005, 32'h00000000, 10, 32'h11111111, 32'h22222222};
        vecs[7] = '{"mult_7_m3",     3'd1, 32'h00000007, 32'hFFFFFFFD,  5, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[8] = '{"div_7_m2",      3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{"multu_max_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1; E_MDOp = 3'd0; E_Start = 1'b0; E_A = 32'd0; E_B = 32'd0; Req = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", 32'(E_Busy), 32'd0);
        chk("reset_hi", E_HI, 32'd0);
        chk("reset_lo", E_LO, 32'd0);

        // Idle mthi writes HI at the next edge.
        mt(3'd5, 32'h12345678);
        chk("mthi_idle", E_HI, 32'h12345678);

        // Vector table: latency, old HI/LO during busy, committed result.
        for (int i = 0; i < 10; i++) begin
            preload(32'h11111111, 32'h22222222);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            n = 0;
            while (E_Busy && n < 50) begin
                n++;
                if (n == 1) begin
                    chk({vecs[i].name, "_old_hi"}, E_HI, 32'h11111111);
                    chk({vecs[i].name, "_old_lo"}, E_LO, 32'h22222222);
                end
                step();
            end
            chk({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_hi"}, E_HI, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, E_LO, vecs[i].lo);
        end

        // Second mult and mtlo while busy, and a start in the final busy cycle: all ignored.
        preload(32'h0000AAAA, 32'h0000BBBB);
        issue(3'd1, 32'd3, 32'd4);
        E_MDOp = 3'd1; E_Start = 1'b1; E_A = 32'd5; E_B = 32'd5;
        step();
        E_MDOp = 3'd6; E_Start = 1'b0; E_A = 32'hDEADBEEF;
        step();
        E_MDOp = 3'd0;
        step();
        step();
        chk("busy_last_cycle", 32'(E_Busy), 32'd1);
        chk("busy_last_lo_old", E_LO, 32'h0000BBBB);
        E_MDOp = 3'd1; E_Start = 1'b1; E_A = 32'd5; E_B = 32'd5;
        step();
        E_MDOp = 3'd0; E_Start = 1'b0;
        chk("ignored_start_busy", 32'(E_Busy), 32'd0);
        chk("ignored_start_hi", E_HI, 32'd0);
        chk("ignored_start_lo", E_LO, 32'd12);
        // The next start is accepted once idle.
        issue(3'd1, 32'd2, 32'd2);
        chk("restart_busy", 32'(E_Busy), 32'd1);
        n = 0;
        while (E_Busy && n < 50) begin n++; step(); end
        chk("restart_lo", E_LO, 32'd4);

        // Req suppresses a mult start.
        preload(32'h33333333, 32'h44444444);
        Req = 1'b1;
        issue(3'd1, 32'd9, 32'd9);
        Req = 1'b0;
        chk("req_mult_busy", 32'(E_Busy), 32'd0);
        step();
        chk("req_mult_hi", E_HI, 32'h33333333);
        chk("req_mult_lo", E_LO, 32'h44444444);

        // Req suppresses mtlo.
        Req = 1'b1;
        mt(3'd6, 32'h55555555);
        Req = 1'b0;
        chk("req_mtlo_lo", E_LO, 32'h44444444);

        // Reserved op 7 and op 0 with E_Start do nothing.
        issue(3'd7, 32'h66666666, 32'd1);
        chk("op7_busy", 32'(E_Busy), 32'd0);
        chk("op7_hi", E_HI, 32'h33333333);
        chk("op7_lo", E_LO, 32'h44444444);
        issue(3'd0, 32'h66666666, 32'd1);
        chk("op0_busy", 32'(E_Busy), 32'd0);

        // Req at cycle 3 of an in-flight mult does not cancel it.
        issue(3'd1, 32'd6, 32'd7);
        step();
        step();
        Req = 1'b1;
        step();
        Req = 1'b0;
        n = 3;
        while (E_Busy && n < 50) begin n++; step(); end
        chk("req_inflight_cycles", 32'(n), 32'd5);
        chk("req_inflight_hi", E_HI, 32'd0);
        chk("req_inflight_lo", E_LO, 32'd42);

        // Reset during cycle 4 of a div: immediate clear, no later commit.
        preload(32'h77777777, 32'h88888888);
        issue(3'd3, 32'd100, 32'd7);
        step();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(E_Busy), 32'd0);
        chk("rst_mid_hi", E_HI, 32'd0);
        chk("rst_mid_lo", E_LO, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("rst_after_busy", 32'(E_Busy), 32'd0);
            chk("rst_after_hi", E_HI, 32'd0);
            chk("rst_after_lo", E_LO, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multiply/divide unit scheduler for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and owns the architectural HI and LO registers.
- Models fixed multi-cycle latency with a down-counter and drives E_Busy, which the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo in D.
- Honours the CP0 exception/interrupt request so a victim instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- E_MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored).
- E_Start  input  1  pulse qualifying E_MDOp for 1..4 in the current cycle.
- E_A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- E_B  input  32  rt operand (divisor / multiplier).
- Req  input  1  exception/interrupt taken this cycle; E-stage instruction is being flushed.
- E_Busy  output  1  high while an operation is in flight.
- E_HI  output  32  architectural HI.
- E_LO  output  32  architectural LO.

Behaviour:
- Reset (asynchronous, immediate): cnt=0, E_Busy=0, E_HI=0, E_LO=0, pending results cleared.
- E_Busy is combinational: (cnt != 0).
- Accept rule for ops 1..4: E_Start=1, Req=0 and cnt==0 at a rising edge. On accept:
  - Compute the result from E_A/E_B and store it in internal registers pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Set flag pend_wr=1, or 0 for divide by zero.
- Countdown:
  - Each edge with cnt != 0 decrements cnt.
  - At the edge where cnt==1: if pend_wr, E_HI<=pend_hi and E_LO<=pend_lo; cnt->0.
- Timing: start sampled at edge T gives E_Busy=1 for exactly N cycles after T. New HI/LO are visible in the same cycle E_Busy falls. Old HI/LO are visible throughout busy.
- Start while busy (including the final busy cycle): ignored, with no effect on cnt or pending results. The hazard unit must hold it in D. The next start is accepted the cycle after E_Busy falls.
- mthi/mtlo (ops 5,6): when E_MDOp selects them, Req=0 and cnt==0, write E_A to E_HI or E_LO at the edge; E_Start is not required. Ignored while busy.
- Req=1: suppresses all accepts and mt writes in that cycle. An operation already in flight (cnt != 0) is NOT cancelled and completes normally, because it is older than the faulting instruction.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO} = $signed(A)*$signed(B).
  - multu: unsigned 32x32->64.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): full DIV_CYCLES busy, HI/LO unchanged.
- Reserved op 7, or op 0 with E_Start: no effect.
- Reset asserted mid-operation: busy drops immediately; no commit occurs after release.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002 -> E_Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11111111, LO=0x22222222; div A=5, B=0 -> busy 10 cycles, HI/LO still 0x11111111/0x22222222.
- Idle mthi A=0x12345678 -> HI=0x12345678 next cycle. During a mult, pulse a second mult and an mtlo -> both ignored, and the first result commits at cycle 5.
- Req=1 with mult start -> E_Busy stays 0 and HI/LO unchanged. Req=1 with mtlo -> LO unchanged. Req=1 at cycle 3 of an in-flight mult -> result still commits at cycle 5.
- Assert reset during cycle 4 of a div -> E_Busy, HI and LO read 0 immediately. After release, no commit appears within the next 10 cycles.
